pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic data payload plus a control field through a valid/ready handshake. It holds a 2-entry skid buffer so upstream ready is registered, never combinational from downstream. Stall comes from downstream back-pressure and flush inserts a bubble, so hazard logic can stall or squash any stage without per-stage custom registers.

## Interface
Parameters:
- DATA_W, 32: payload width (ALU result, operands, targets, register numbers packed by the instantiating stage).
- CTRL_W, 8: control-field width (MemRead, MemWrite, Branch, RegWrite, MemToReg, ...); forced to 0 on bubble/flush.
- NEGEDGE, 1: 1 means all state captures on the falling edge of clk; 0 means the rising edge. The selected edge is called the "active edge" below.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- flush, in, 1: squash all held entries at the next active edge.
- in_valid, in, 1: upstream offers in_data/in_ctrl.
- in_ready, out, 1: stage can accept; registered, equal to NOT skid_valid.
- in_data, in, DATA_W: payload.
- in_ctrl, in, CTRL_W: control field.
- out_valid, out, 1: out_data/out_ctrl hold a real instruction.
- out_ready, in, 1: downstream accepts (0 = stall).
- out_data, out, DATA_W: payload to the next stage.
- out_ctrl, out, CTRL_W: control to the next stage; 0 whenever out_valid=0.
- occ, out, 2: entries held, equal to out_valid + skid_valid (0..2).

## Operation
Internal state:
- Main entry: out_valid, out_data, out_ctrl.
- Skid entry: skid_valid, skid_data, skid_ctrl.

Definitions:
- Input handshake: accept = in_valid & in_ready.
- Output handshake: take = out_valid & out_ready.
- Main free: free = !out_valid | out_ready.

At each active edge, evaluated in priority order:
1. flush=1: out_valid=0, skid_valid=0, out_ctrl=0, out_data unchanged. The offered input is dropped even if accept=1.
2. free and skid_valid: main loads the skid entry; skid_valid=0. (in_ready was 0, so nothing is accepted this edge.)
3. free and !skid_valid and accept: main loads the input; out_valid=1.
4. free and no source: out_valid=0, out_ctrl=0 (bubble), out_data unchanged.
5. !free and accept: skid loads the input; skid_valid=1.
6. Otherwise: hold.

Guarantees:
- Ordering is preserved and no entry is duplicated or lost except by flush.
- skid_valid=1 implies out_valid=1.
- Reset (asynchronous, any time, including mid-stall): out_valid=0, out_data=0, out_ctrl=0, skid_valid=0, skid_data=0, skid_ctrl=0, occ=0, in_ready=1. All held entries are discarded.
- No X propagation: out_ctrl is never driven from an invalid source.

## Timing
- Latency: in→out is 1 active edge when not stalled. Throughput is 1 entry per cycle with out_ready held at 1.
- in_ready depends only on registered state. It drops the active edge after a stalled accept fills the skid, and rises the active edge after the main drains from the skid.
- Stall absorption: 1 extra entry beyond the main register. With out_ready=0, at most 2 entries are accepted; in_ready stays 0 until out_ready returns.
- Flush with out_ready=1 on the same edge: the downstream handshake on the current out_* still completes (take counts). The stage is empty afterwards.
- Flush with in_valid=1: the upstream sees in_ready=1 and considers the item sent. Upstream must be flushed by the same hazard logic.
- rst_n deassertion is synchronised by the top level. The first capture is the first active edge after release.

## Test plan
- Reset mid-stall: fill to occ=2 with out_ready=0, pulse rst_n low between edges → out_valid=0, out_ctrl=0, occ=0, in_ready=1 immediately, before any edge.
- Streaming: DATA_W=32, CTRL_W=8, out_ready=1, in_data=1..8 on consecutive cycles, in_ctrl=8'hA5 → out_data=1..8 one active edge later each, with no gaps.
- Stall/skid: send 0x11, 0x22, 0x33 with out_ready=0 from the second edge → occ=2, in_ready=0, 0x33 held upstream. Release out_ready → outputs 0x11, 0x22, 0x33 in order, in_ready=1 one edge after 0x22 moves to main.
- Flush: occ=2 (0x44 main, 0x55 skid), assert flush with in_valid=1 carrying 0x66 → next edge: occ=0, out_valid=0, out_ctrl=0, and 0x66 never appears.
- Bubble: single item in_ctrl=8'hFF, then in_valid=0 → out_ctrl=8'hFF for one cycle, then 8'h00 with out_valid=0.
- NEGEDGE=0 vs 1: repeat the streaming test under each setting → captures occur only on the selected clk edge.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Upstream/downstream valid-ready bundle of one pipeline stage.
// Revision    : 1.0  initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occ;

    // Surrounding pipeline: drives offers and back-pressure
    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occ
    );

    // The stage register itself
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occ
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic pipeline stage register with 2-entry skid buffer,
//               registered upstream ready, stall and flush-to-bubble.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 8,
    parameter bit NEGEDGE = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    pipe_stage_reg_if.slave   bus
);
    logic              w_activeClk;
    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic [CTRL_W-1:0] r_outCtrl;
    logic              r_skidValid;
    logic [DATA_W-1:0] r_skidData;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic              w_inReady;
    logic              w_accept;
    logic              w_free;

    // All state lives on a single selectable edge of clk
    generate
        if (NEGEDGE) begin : g_negClk
            assign w_activeClk = ~clk;
        end else begin : g_posClk
            assign w_activeClk = clk;
        end
    endgenerate

    assign w_inReady = ~r_skidValid;
    assign w_accept  = bus.in_valid & w_inReady;
    assign w_free    = ~r_outValid | bus.out_ready;

    always_ff @(posedge w_activeClk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outCtrl   <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
            r_skidCtrl  <= '0;
        end else if (flush) begin
            r_outValid  <= 1'b0;
            r_outCtrl   <= '0;
            r_skidValid <= 1'b0;
        end else if (w_free) begin
            if (r_skidValid) begin
                r_outValid  <= 1'b1;
                r_outData   <= r_skidData;
                r_outCtrl   <= r_skidCtrl;
                r_skidValid <= 1'b0;
            end else if (w_accept) begin
                r_outValid <= 1'b1;
                r_outData  <= bus.in_data;
                r_outCtrl  <= bus.in_ctrl;
            end else begin
                // Bubble: control is zeroed so the next stage sees a no-op
                r_outValid <= 1'b0;
                r_outCtrl  <= '0;
            end
        end else if (w_accept) begin
            r_skidValid <= 1'b1;
            r_skidData  <= bus.in_data;
            r_skidCtrl  <= bus.in_ctrl;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_ctrl  = r_outCtrl;
    assign bus.occ       = {1'b0, r_outValid} + {1'b0, r_skidValid};

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed table-driven bench for pipe_stage_reg (both edges).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;
    logic clk;
    logic rst_n;
    logic flushN;
    logic flushP;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) ifN ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) ifP ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .NEGEDGE(1'b1)) dutN (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flushN),
        .bus   (ifN.slave)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .NEGEDGE(1'b0)) dutP (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flushP),
        .bus   (ifP.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        inValid;
        logic [31:0] inData;
        logic [7:0]  inCtrl;
        logic        outReady;
        logic        expValid;
        logic [31:0] expData;
        logic [7:0]  expCtrl;
        logic [1:0]  expOcc;
        logic        expReady;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(logic f, logic v, logic [31:0] d, logic [7:0] c, logic r,
                                logic ev, logic [31:0] ed, logic [7:0] ec,
                                logic [1:0] eo, logic er);
        vec_t t;
        t.flush = f;   t.inValid = v;  t.inData = d;   t.inCtrl = c;  t.outReady = r;
        t.expValid = ev; t.expData = ed; t.expCtrl = ec; t.expOcc = eo; t.expReady = er;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveN(input logic f, input logic v, input logic [31:0] d,
                          input logic [7:0] c, input logic r);
        flushN        = f;
        ifN.in_valid  = v;
        ifN.in_data   = d;
        ifN.in_ctrl   = c;
        ifN.out_ready = r;
    endtask

    task automatic checkN(input string tag, input vec_t t);
        check({tag, ".valid"}, {31'd0, ifN.out_valid}, {31'd0, t.expValid});
        check({tag, ".ctrl"},  {24'd0, ifN.out_ctrl},  {24'd0, t.expCtrl});
        check({tag, ".occ"},   {30'd0, ifN.occ},       {30'd0, t.expOcc});
        check({tag, ".ready"}, {31'd0, ifN.in_ready},  {31'd0, t.expReady});
        if (t.expValid)
            check({tag, ".data"}, ifN.out_data, t.expData);
    endtask

    // Watchdog keeps the run bounded regardless of DUT behaviour
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        driveN(1'b0, 1'b0, 32'd0, 8'd0, 1'b1);
        flushP        = 1'b0;
        ifP.in_valid  = 1'b0;
        ifP.in_data   = 32'd0;
        ifP.in_ctrl   = 8'd0;
        ifP.out_ready = 1'b1;

        // Streaming
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 1, k, 8'hA5, 1,  1, k, 8'hA5, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1,  0, 0, 8'h00, 2'd0, 1));
        // Stall / skid
        vecs.push_back(mk(0, 1, 32'h11, 8'h11, 1,  1, 32'h11, 8'h11, 2'd1, 1));
        vecs.push_back(mk(0, 1, 32'h22, 8'h22, 0,  1, 32'h11, 8'h11, 2'd2, 0));
        vecs.push_back(mk(0, 1, 32'h33, 8'h33, 0,  1, 32'h11, 8'h11, 2'd2, 0));
        vecs.push_back(mk(0, 1, 32'h33, 8'h33, 0,  1, 32'h11, 8'h11, 2'd2, 0));
        vecs.push_back(mk(0, 1, 32'h33, 8'h33, 1,  1, 32'h22, 8'h22, 2'd1, 1));
        vecs.push_back(mk(0, 1, 32'h33, 8'h33, 1,  1, 32'h33, 8'h33, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1,  0, 0, 8'h00, 2'd0, 1));
        // Flush with a live offer
        vecs.push_back(mk(0, 1, 32'h44, 8'h44, 0,  1, 32'h44, 8'h44, 2'd1, 1));
        vecs.push_back(mk(0, 1, 32'h55, 8'h55, 0,  1, 32'h44, 8'h44, 2'd2, 0));
        vecs.push_back(mk(1, 1, 32'h66, 8'h66, 0,  0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1,  0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1,  0, 0, 8'h00, 2'd0, 1));
        // Bubble
        vecs.push_back(mk(0, 1, 32'h77, 8'hFF, 1,  1, 32'h77, 8'hFF, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1,  0, 0, 8'h00, 2'd0, 1));

        // Reset state
        #12;
        checkN("reset", mk(0, 0, 0, 0, 0,  0, 0, 8'h00, 2'd0, 1));
        check("resetP.valid", {31'd0, ifP.out_valid}, 32'd0);
        check("resetP.ready", {31'd0, ifP.in_ready},  32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            driveN(vecs[i].flush, vecs[i].inValid, vecs[i].inData, vecs[i].inCtrl, vecs[i].outReady);
            @(negedge clk); #1;
            checkN($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset mid-stall takes effect immediately, without an edge
        driveN(0, 1, 32'hAA, 8'h0A, 0);
        @(negedge clk); #1;
        driveN(0, 1, 32'hBB, 8'h0B, 0);
        @(negedge clk); #1;
        checkN("fill", mk(0, 0, 0, 0, 0,  1, 32'hAA, 8'h0A, 2'd2, 0));
        driveN(0, 0, 32'd0, 8'd0, 0);
        #1 rst_n = 1'b0;
        #1;
        checkN("asyncReset", mk(0, 0, 0, 0, 0,  0, 0, 8'h00, 2'd0, 1));
        #4 rst_n = 1'b1;

        // NEGEDGE=1 instance ignores the rising edge
        @(negedge clk); #1;
        driveN(0, 1, 32'hCC, 8'hCC, 1);
        @(posedge clk); #1;
        check("negOnly.noPosCapture", {31'd0, ifN.out_valid}, 32'd0);
        @(negedge clk); #1;
        check("negOnly.valid", {31'd0, ifN.out_valid}, 32'd1);
        check("negOnly.data",  ifN.out_data, 32'hCC);
        driveN(0, 0, 32'd0, 8'd0, 1);

        // NEGEDGE=0 instance: streaming, capturing only on the rising edge
        @(posedge clk); #1;
        for (int k = 1; k <= 8; k++) begin
            ifP.in_valid = 1'b1;
            ifP.in_data  = k;
            ifP.in_ctrl  = 8'hA5;
            @(negedge clk); #1;
            check($sformatf("pos%0d.noNegCapture", k), {31'd0, ifP.out_valid}, (k == 1) ? 32'd0 : 32'd1);
            if (k > 1)
                check($sformatf("pos%0d.heldData", k), ifP.out_data, k - 1);
            @(posedge clk); #1;
            check($sformatf("pos%0d.valid", k), {31'd0, ifP.out_valid}, 32'd1);
            check($sformatf("pos%0d.data", k),  ifP.out_data, k);
            check($sformatf("pos%0d.ctrl", k),  {24'd0, ifP.out_ctrl}, 32'hA5);
        end
        ifP.in_valid = 1'b0;
        @(posedge clk); #1;
        check("posBubble.valid", {31'd0, ifP.out_valid}, 32'd0);
        check("posBubble.ctrl",  {24'd0, ifP.out_ctrl},  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
